led_event_indicator: RTL and testbench
======================================

Name: led_event_indicator

Overview:
- Output-side counterpart to the push-button input path.
- Converts single-cycle event pulses into human-visible LED flashes, one distinct flash per event.
- Events arriving while a flash is in progress are queued in a saturating pending counter and replayed back-to-back, separated by a dark gap.
- Sits between control logic producing one-cycle strobes and a board LED pin.

Parameters:
- ON_CYCLES, 25_000_000, LED-on duration per flash in clk_i cycles (250 ms at 100 MHz); must be >= 1.
- GAP_CYCLES, 25_000_000, LED-off gap after each flash in clk_i cycles; must be >= 1.
- PEND_W, 3, width of the pending-event counter; saturates at 2**PEND_W-1.
- PWM_DUTY, 16, on-ticks per 16-cycle PWM frame, range 0..16; used only with LED_ENABLE_PWM_EN.

Ports:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  synchronous, active-high reset.
- event_i  input  1  event strobe; every cycle sampled high counts as one event.
- led  output  1  LED drive.
- busy_o  output  1  high whenever the FSM is not IDLE.
- pend_o  output  PEND_W  events queued and not yet flashed.
- overflow_o  output  1  sticky; set when an event is dropped at saturation.

Behaviour:
- Reset: on a rising edge with rst_i=1, the next cycle shows:
  - FSM in IDLE, timer 0.
  - led=0, busy_o=0, pend_o=0, overflow_o=0.
  - PWM frame counter 0.
  - Reset overrides all other activity, including mid-flash; no flash resumes afterwards.
- FSM states: IDLE, ON, GAP. All outputs are registered.
- IDLE:
  - event_i=1 → ON on the next cycle (latency 1). led=1 from that cycle.
  - pend_o>0 cannot occur in IDLE.
- ON:
  - led=1 for exactly ON_CYCLES consecutive cycles, then → GAP.
- GAP:
  - led=0 for exactly GAP_CYCLES cycles.
  - On the last GAP cycle:
    - pend_o>0 → ON, pend_o decrements by 1.
    - else event_i=1 → ON, event consumed directly, pend_o unchanged.
    - else → IDLE.
- Pending counter:
  - event_i=1 in ON or GAP (except a last-GAP-cycle event consumed directly) increments pend_o.
  - Increment and decrement in the same cycle → net unchanged.
  - At saturation (all ones) a further event is dropped, pend_o holds, and overflow_o sets; it clears only on reset.
- busy_o = (state != IDLE), registered with state.
- Timer:
  - Down-counter loaded with ON_CYCLES-1 on entry to ON and GAP_CYCLES-1 on entry to GAP.
  - State exits on the cycle the timer is 0.
  - Width is clog2(max(ON_CYCLES, GAP_CYCLES)).

Optional Feature:
- Macro LED_ENABLE_PWM_EN.
- Defined:
  - A free-running 4-bit frame counter runs during ON.
  - It is reset to 0 on ON entry.
  - In ON, led = (frame_cnt < PWM_DUTY), for dimmed flashes. PWM_DUTY=16 gives solid on; 0 gives a dark flash.
  - Timing, busy_o and the pending counter are unaffected.
- Undefined:
  - No frame counter; led is solid 1 in ON and PWM_DUTY is ignored.

Decomposition:
- Package led_ind_pkg:
  - state enum typedef (IDLE, ON, GAP), 2 bits.
  - PWM frame-width constant (4).
- Sub-module ind_timer: loadable down-counter with load value, load strobe, and zero flag.
- FSM, pending counter and PWM stay in led_event_indicator.

Test Plan:
All directed tests use ON_CYCLES=4, GAP_CYCLES=3, PEND_W=2 unless noted.
- Single event: pulse event_i at cycle 10 → led=1 cycles 11-14, 0 from cycle 15; busy_o=1 cycles 11-17, 0 at cycle 18; pend_o stays 0.
- Burst: event_i at cycles 10, 11, 12 → pend_o=1 at cycle 12, 2 at cycle 13; led high 11-14, 18-21, 25-28; pend_o=1 at cycle 18, 0 at cycle 25; IDLE at cycle 32.
- Saturation: event at cycle 10, then event_i held high cycles 11-15 → pend_o=3 from cycle 14, overflow_o=1 from cycle 15 and stays 1 through IDLE.
- Last-gap chaining: single event at cycle 10, second event at cycle 17 (last GAP cycle) → led high again 18-21, pend_o 0 throughout.
- Reset mid-flash: event at cycle 10, pend_o=2, rst_i=1 at cycle 13 → cycle 14 led=0, pend_o=0, busy_o=0, overflow_o=0; no further flashes.
- LED_ENABLE_PWM_EN, ON_CYCLES=32, PWM_DUTY=8: single event → led alternates 8 cycles high / 8 cycles low for 32 cycles; busy_o high 32+GAP_CYCLES cycles.

Source files
------------

// File: rtl/led_ind_pkg.sv
// Shared types and constants for the LED event indicator: FSM state encoding,
// PWM frame width and the timer width helper.
package led_ind_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam int PWM_FRAME_W = 4;

  // Wide enough to hold max(a,b)-1; never narrower than one bit.
  function automatic int tmr_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/ind_timer.sv
// Loadable down-counter: load wins, otherwise counts toward zero and parks there.
// zero flag is combinational from the count register (valid the cycle after load).
module ind_timer #(
  parameter int W = 1
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/led_event_indicator.sv
// Turns one-cycle event strobes into timed LED flashes with a dark gap, replaying queued events;
// all outputs registered, led rises one cycle after the event. Optional dimming: LED_ENABLE_PWM_EN.
module led_event_indicator
  import led_ind_pkg::*;
#(
  parameter int ON_CYCLES  = 25_000_000,
  parameter int GAP_CYCLES = 25_000_000,
  parameter int PEND_W     = 3,
  parameter int PWM_DUTY   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              event_i,
  output logic              led,
  output logic              busy_o,
  output logic [PEND_W-1:0] pend_o,
  output logic              overflow_o
);

  localparam int                TMR_W    = tmr_width(ON_CYCLES, GAP_CYCLES);
  localparam logic [TMR_W-1:0]  ON_LOAD  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0]  GAP_LOAD = TMR_W'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  if (ON_CYCLES < 1 || GAP_CYCLES < 1 || PWM_DUTY < 0 || PWM_DUTY > 16) begin : g_bad_param
    $error("led_event_indicator: illegal parameter value");
  end

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_dec;
  logic                w_direct;
  logic                w_inc;
  logic                w_tmr_zero;
  logic                w_tmr_load;
  logic [TMR_W-1:0]    w_tmr_val;
  logic [PEND_W-1:0]   r_pend;
  logic [PEND_W-1:0]   w_pend_nxt;
  logic                r_ovf;
  logic                w_ovf_nxt;
  logic                r_led;
  logic                w_led_nxt;
  logic                r_busy;

  ind_timer #(.W(TMR_W)) u_timer (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_zero     (w_tmr_zero)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Queued events take priority over a fresh strobe on the last gap cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_dec       = 1'b0;
    w_direct    = 1'b0;
    case (r_state)
      ST_IDLE: if (event_i) w_state_nxt = ST_ON;
      ST_ON:   if (w_tmr_zero) w_state_nxt = ST_GAP;
      ST_GAP: begin
        if (w_tmr_zero) begin
          if (r_pend != '0) begin
            w_state_nxt = ST_ON;
            w_dec       = 1'b1;
          end else if (event_i) begin
            w_state_nxt = ST_ON;
            w_direct    = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef LED_ENABLE_PWM_EN
  localparam logic [PWM_FRAME_W:0] DUTY = (PWM_FRAME_W + 1)'(PWM_DUTY);

  logic [PWM_FRAME_W-1:0] r_frame;
  logic [PWM_FRAME_W-1:0] w_frame_nxt;

  always_comb begin
    w_frame_nxt = r_frame;
    if (w_state_nxt == ST_ON && r_state != ST_ON) begin
      w_frame_nxt = '0;
    end else if (r_state == ST_ON) begin
      w_frame_nxt = r_frame + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_frame <= '0;
    end else begin
      r_frame <= w_frame_nxt;
    end
  end

  assign w_led_nxt = (w_state_nxt == ST_ON) && ({1'b0, w_frame_nxt} < DUTY);
`else
  assign w_led_nxt = (w_state_nxt == ST_ON);
`endif

  always_comb begin
    w_tmr_load = (w_state_nxt != r_state) && (w_state_nxt != ST_IDLE);
    w_tmr_val  = (w_state_nxt == ST_ON) ? ON_LOAD : GAP_LOAD;
    w_inc      = event_i && (r_state != ST_IDLE) && !w_direct;
    w_pend_nxt = r_pend;
    w_ovf_nxt  = r_ovf;
    if (w_inc && !w_dec) begin
      if (r_pend == PEND_MAX) begin
        w_ovf_nxt = 1'b1;
      end else begin
        w_pend_nxt = r_pend + 1'b1;
      end
    end else if (w_dec && !w_inc) begin
      w_pend_nxt = r_pend - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= '0;
      r_ovf  <= 1'b0;
      r_led  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_pend <= w_pend_nxt;
      r_ovf  <= w_ovf_nxt;
      r_led  <= w_led_nxt;
      r_busy <= (w_state_nxt != ST_IDLE);
    end
  end

  assign led        = r_led;
  assign busy_o     = r_busy;
  assign pend_o     = r_pend;
  assign overflow_o = r_ovf;

endmodule

// File: tb/tb_led_event_indicator.sv
// Bench for led_event_indicator: flash-schedule reference model checked every cycle,
// directed literal timelines, then randomized events and resets.
module tb_led_event_indicator;

  localparam int ON   = 4;
  localparam int GAP  = 3;
  localparam int PW   = 2;
  localparam int DUTY = 16;
  localparam int PMAX = (1 << PW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ev  = 1'b0;
  logic          led;
  logic          busy;
  logic [PW-1:0] pend;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  led_event_indicator #(
    .ON_CYCLES  (ON),
    .GAP_CYCLES (GAP),
    .PEND_W     (PW),
    .PWM_DUTY   (DUTY)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .event_i    (ev),
    .led        (led),
    .busy_o     (busy),
    .pend_o     (pend),
    .overflow_o (ovf)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a flash occupies ON+GAP cycles counted from its start; t is the offset.
  logic m_busy = 1'b0;
  int   m_t    = 0;
  int   m_pend = 0;
  logic m_ovf  = 1'b0;
  logic m_inc;
  logic m_dec;

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_t    <= 0;
      m_pend <= 0;
      m_ovf  <= 1'b0;
    end else if (!m_busy) begin
      if (ev) begin
        m_busy <= 1'b1;
        m_t    <= 0;
      end
    end else begin
      m_inc = ev;
      m_dec = 1'b0;
      if (m_t == ON + GAP - 1) begin
        if (m_pend > 0) begin
          m_t   <= 0;
          m_dec = 1'b1;
        end else if (ev) begin
          m_t   <= 0;
          m_inc = 1'b0;
        end else begin
          m_busy <= 1'b0;
        end
      end else begin
        m_t <= m_t + 1;
      end
      if (m_inc && !m_dec) begin
        if (m_pend == PMAX) m_ovf <= 1'b1;
        else m_pend <= m_pend + 1;
      end else if (m_dec && !m_inc) begin
        m_pend <= m_pend - 1;
      end
    end
  end

  function automatic int model_led();
    int on_now;
    on_now = (m_busy && m_t < ON) ? 1 : 0;
`ifdef LED_ENABLE_PWM_EN
    if ((m_t % 16) >= DUTY) on_now = 0;
`endif
    return on_now;
  endfunction

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("model_led", int'(led), model_led());
      chk("model_busy", int'(busy), int'(m_busy));
      chk("model_pend", int'(pend), m_pend);
      chk("model_ovf", int'(ovf), int'(m_ovf));
    end
  end

  int led_l[64];
  int busy_l[64];
  int pend_l[64];
  int ovf_l[64];

  // Cycle 0 is the first cycle after the reset edge; ev bit k is driven during cycle k.
  task automatic run(input logic [63:0] evm, input int rst_at, input int n);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < n; k++) begin
      ev  = evm[k];
      rst = (k == rst_at);
      @(negedge clk);
      led_l[k]  = int'(led);
      busy_l[k] = int'(busy);
      pend_l[k] = int'(pend);
      ovf_l[k]  = int'(ovf);
      @(posedge clk);
      #1;
    end
    ev  = 1'b0;
    rst = 1'b0;
  endtask

  function automatic int max_of(input int arr[64], input int lo, input int hi);
    int m;
    m = 0;
    for (int i = lo; i <= hi; i++) if (arr[i] > m) m = arr[i];
    return m;
  endfunction

  initial begin
    logic [63:0] m;
    @(posedge clk);
    #1 cmp_en = 1'b1;

    // Single event
    m = '0; m[10] = 1'b1;
    run(m, -1, 40);
    chk("rst_led", led_l[0], 0);
    chk("rst_busy", busy_l[0], 0);
    chk("rst_pend", pend_l[0], 0);
    chk("rst_ovf", ovf_l[0], 0);
    chk("single_led_c10", led_l[10], 0);
    for (int c = 11; c <= 14; c++) chk("single_led_on", led_l[c], 1);
    chk("single_led_c15", led_l[15], 0);
    chk("single_busy_c17", busy_l[17], 1);
    chk("single_busy_c18", busy_l[18], 0);
    chk("single_pend_max", max_of(pend_l, 0, 39), 0);

    // Burst of three
    m = '0; m[10] = 1'b1; m[11] = 1'b1; m[12] = 1'b1;
    run(m, -1, 40);
    chk("burst_pend_c12", pend_l[12], 1);
    chk("burst_pend_c13", pend_l[13], 2);
    chk("burst_led_c17", led_l[17], 0);
    chk("burst_led_c18", led_l[18], 1);
    chk("burst_pend_c18", pend_l[18], 1);
    chk("burst_led_c24", led_l[24], 0);
    chk("burst_led_c25", led_l[25], 1);
    chk("burst_pend_c25", pend_l[25], 0);
    chk("burst_led_c28", led_l[28], 1);
    chk("burst_led_c29", led_l[29], 0);
    chk("burst_busy_c31", busy_l[31], 1);
    chk("burst_busy_c32", busy_l[32], 0);

    // Saturation
    m = '0;
    for (int c = 10; c <= 15; c++) m[c] = 1'b1;
    run(m, -1, 45);
    chk("sat_pend_c13", pend_l[13], 2);
    chk("sat_pend_c14", pend_l[14], 3);
    chk("sat_ovf_c14", ovf_l[14], 0);
    chk("sat_ovf_c15", ovf_l[15], 1);
    chk("sat_busy_c38", busy_l[38], 1);
    chk("sat_busy_c39", busy_l[39], 0);
    chk("sat_ovf_c44", ovf_l[44], 1);

    // Last-gap chaining
    m = '0; m[10] = 1'b1; m[17] = 1'b1;
    run(m, -1, 30);
    chk("chain_rst_ovf", ovf_l[0], 0);
    for (int c = 18; c <= 21; c++) chk("chain_led_on", led_l[c], 1);
    chk("chain_led_c22", led_l[22], 0);
    chk("chain_busy_c24", busy_l[24], 1);
    chk("chain_busy_c25", busy_l[25], 0);
    chk("chain_pend_max", max_of(pend_l, 0, 29), 0);

    // Reset mid-flash
    m = '0; m[10] = 1'b1; m[11] = 1'b1; m[12] = 1'b1;
    run(m, 13, 40);
    chk("rstmid_pend_c13", pend_l[13], 2);
    chk("rstmid_led_c13", led_l[13], 1);
    chk("rstmid_led_c14", led_l[14], 0);
    chk("rstmid_busy_c14", busy_l[14], 0);
    chk("rstmid_pend_c14", pend_l[14], 0);
    chk("rstmid_ovf_c14", ovf_l[14], 0);
    chk("rstmid_led_after", max_of(led_l, 14, 39), 0);
    chk("rstmid_busy_after", max_of(busy_l, 14, 39), 0);

    // Random traffic: sparse, then dense enough to saturate, with rare resets
    for (int k = 0; k < 3000; k++) begin
      if (k < 1500) ev = ($urandom_range(0, 5) == 0);
      else          ev = ($urandom_range(0, 1) == 0);
      rst = ($urandom_range(0, 399) == 0);
      @(posedge clk);
      #1;
    end
    ev  = 1'b0;
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1 cmp_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
